// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four WIDTH-bit sources sharing one registered output
// stage; grants are held for up to MAX_BURST beats or until the source drops req.
//
// state | meaning
// IDLE  | no grant held; arbitrate among req starting after last
// GRANT | gnt/sel hold one source; beats move to dout on ack
module rr_mux4_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t           state;
    logic [1:0]       last;
    logic [3:0]       beats;
    logic             space;
    logic             cur_ack;
    logic             last_beat;
    logic [WIDTH-1:0] din_sel;
    logic [1:0]       cand;
    logic [1:0]       pick_idx;
    logic             pick_vld;

    always_comb begin
        space     = ~out_valid | out_ready;
        ack       = (state == GRANT) ? (gnt & req & {4{space}}) : 4'b0000;
        cur_ack   = |ack;
        last_beat = cur_ack && (beats == LAST_CNT);
    end

    always_comb begin
        case (sel)
            2'd0:    din_sel = din0;
            2'd1:    din_sel = din1;
            2'd2:    din_sel = din2;
            default: din_sel = din3;
        endcase
    end

    // Rotating scan: first requester after the previous winner takes the grant.
    always_comb begin
        cand     = 2'd0;
        pick_idx = 2'd0;
        pick_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd3;
            beats     <= 4'd0;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            busy      <= 1'b0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= GRANT;
                        sel   <= pick_idx;
                        gnt   <= 4'b0001 << pick_idx;
                        beats <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (cur_ack)
                        beats <= beats + 4'd1;
                    if (last_beat || !req[sel]) begin
                        state <= IDLE;
                        last  <= sel;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cur_ack) begin
                dout      <= din_sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: per-cycle vector table plus a hand-written
// asynchronous reset sequence. Source data advances only on its ack bit.
module tb_rr_mux4_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] ack;
    logic [7:0] dout;
    logic       out_valid;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] cnt [4];

    rr_mux4_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .ack       (ack),
        .dout      (dout),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source model: each requester steps to its next beat when acked.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (ack[i]) cnt[i] <= cnt[i] + 8'd1;
        end
    end

    assign din0 = 8'hA0 + cnt[0];
    assign din1 = 8'hB0 + cnt[1];
    assign din2 = 8'h10 + cnt[2];
    assign din3 = 8'h30 + cnt[3];

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] e_ack;
        logic [3:0] e_gnt;
        logic [1:0] e_sel;
        logic [7:0] e_dout;
        logic       e_vld;
        logic       e_busy;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input bit r, input logic [3:0] rq, input logic rd,
                                input logic [3:0] ea, input logic [3:0] eg,
                                input logic [1:0] es, input logic [7:0] ed,
                                input logic ev, input logic eb);
        vec_t v;
        v.do_rst = r;  v.req = rq;  v.rdy = rd;  v.e_ack = ea;  v.e_gnt = eg;
        v.e_sel = es;  v.e_dout = ed;  v.e_vld = ev;  v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.do_rst) do_reset();
        @(negedge clk);
        req       = v.req;
        out_ready = v.rdy;
        #1;
        chk($sformatf("v%0d_ack", idx), 32'(ack), 32'(v.e_ack));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_gnt", idx), 32'(gnt), 32'(v.e_gnt));
        chk($sformatf("v%0d_sel", idx), 32'(sel), 32'(v.e_sel));
        chk($sformatf("v%0d_dout", idx), 32'(dout), 32'(v.e_dout));
        chk($sformatf("v%0d_vld", idx), 32'(out_valid), 32'(v.e_vld));
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.e_busy));
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;

        // single requester 2: four beats, one idle cycle, re-grant
        tbl.push_back(mk(1, 4'b0100, 1, 4'b0000, 4'b0100, 2, 8'h00, 0, 1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 2, 8'h10, 1, 1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 2, 8'h11, 1, 1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 2, 8'h12, 1, 1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0000, 2, 8'h13, 1, 0));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 4'b0100, 2, 8'h13, 0, 1));
        tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 4'b0100, 2, 8'h14, 1, 1));

        // fairness: all four requesting, order 0,1,2,3,0
        tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 4'b0001, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0001, 0, 8'hA0, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0001, 0, 8'hA1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0001, 0, 8'hA2, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0000, 0, 8'hA3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 4'b0010, 1, 8'hA3, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 4'b0010, 1, 8'hB0, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 4'b0010, 1, 8'hB1, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 4'b0010, 1, 8'hB2, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 4'b0000, 1, 8'hB3, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 4'b0100, 2, 8'hB3, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 4'b0100, 2, 8'h10, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 4'b0100, 2, 8'h11, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 4'b0100, 2, 8'h12, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 4'b0000, 2, 8'h13, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 4'b1000, 3, 8'h13, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 4'b1000, 3, 8'h30, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 4'b1000, 3, 8'h31, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 4'b1000, 3, 8'h32, 1, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 4'b0000, 3, 8'h33, 1, 0));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 4'b0001, 0, 8'h33, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 4'b0001, 0, 8'hA4, 1, 1));

        // backpressure on requester 1: three stalled cycles after first beat
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0000, 4'b0010, 1, 8'h00, 0, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 8'hB0, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0010, 1, 8'hB0, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0010, 1, 8'hB0, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 4'b0010, 1, 8'hB0, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 8'hB1, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0010, 1, 8'hB2, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 4'b0000, 1, 8'hB3, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'hB3, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hB3, 0, 0));

        // early release: requester 0 drops after two beats, then re-requests
        tbl.push_back(mk(1, 4'b0011, 1, 4'b0000, 4'b0001, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0001, 4'b0001, 0, 8'hA0, 1, 1));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0001, 4'b0001, 0, 8'hA1, 1, 1));
        tbl.push_back(mk(0, 4'b0010, 1, 4'b0000, 4'b0000, 0, 8'hA1, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0000, 4'b0010, 1, 8'hA1, 0, 1));
        tbl.push_back(mk(0, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'hB0, 1, 1));

        foreach (tbl[i]) apply(tbl[i], i);

        // asynchronous reset during the second beat of a grant to requester 3
        apply(mk(1, 4'b1000, 1, 4'b0000, 4'b1000, 3, 8'h00, 0, 1), 100);
        apply(mk(0, 4'b1000, 1, 4'b1000, 4'b1000, 3, 8'h30, 1, 1), 101);
        @(negedge clk);
        req       = 4'b1000;
        out_ready = 1'b1;
        #1;
        chk("ar_ack_pre", 32'(ack), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_sel", 32'(sel), 32'h0);
        chk("ar_dout", 32'(dout), 32'h0);
        chk("ar_vld", 32'(out_valid), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_ack", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        chk("ar_ack_hold", 32'(ack), 32'h0);
        chk("ar_gnt_hold", 32'(gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1001;
        #1;
        chk("ar_ack_idle", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        chk("ar_regnt", 32'(gnt), 32'h1);
        chk("ar_resel", 32'(sel), 32'h0);
        chk("ar_rebusy", 32'(busy), 32'h1);
        apply(mk(0, 4'b1001, 1, 4'b0001, 4'b0001, 0, 8'hA0, 1, 1), 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
